// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: sized loads/stores on a word array with a fixed-latency, stallable response pipe
package dmem_pkg;
   localparam int ROB_SIZE_BITS = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wr_data;
      logic        MemWrite;
      logic        MemRead;
   } memReqStruct;

   typedef struct packed {
      logic [31:0] rd_data;
      logic        valid;
   } memRespStruct;
endpackage

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ROB_BITS    = ROB_SIZE_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  memReqStruct         req,
   input  logic [2:0]          req_funct3,
   input  logic [ROB_BITS-1:0] req_robNum,
   output logic                req_ready,
   output memRespStruct        resp,
   output logic [ROB_BITS-1:0] resp_robNum,
   output logic                resp_is_store,
   output logic                resp_err,
   input  logic                resp_ready
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]         mem [DEPTH_WORDS];

   logic [LATENCY-1:0]  st_valid;
   logic [LATENCY-1:0]  st_store;
   logic [LATENCY-1:0]  st_err;
   logic [31:0]         st_data [LATENCY];
   logic [ROB_BITS-1:0] st_rob  [LATENCY];

   logic                stall;
   logic                present;
   logic                accept;
   logic                is_store;
   logic                acc_err;
   logic [AW-1:0]       widx;
   logic [1:0]          boff;
   logic [31:0]         rword;
   logic [31:0]         ld_data;
   logic [31:0]         wr_word;
   logic [3:0]          wr_be;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic                unused_addr_bits;

   // The only stall source is an unconsumed valid response at the output stage.
   assign stall     = st_valid[LATENCY-1] & ~resp_ready;
   assign req_ready = ~stall;
   assign present   = req.MemRead | req.MemWrite;
   assign accept    = present & req_ready;
   assign is_store  = req.MemWrite;

   assign widx             = req.addr[AW+1:2];
   assign boff             = req.addr[1:0];
   assign unused_addr_bits = ^req.addr[31:AW+2];
   assign rword            = mem[widx];
   assign ld_byte          = rword[{boff, 3'b000} +: 8];
   assign ld_half          = boff[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      acc_err = 1'b0;
      wr_be   = 4'b0000;
      wr_word = req.wr_data;
      ld_data = 32'd0;
      if (is_store) begin
         case (req_funct3)
            3'b000: begin
               wr_be   = 4'b0001 << boff;
               wr_word = {4{req.wr_data[7:0]}};
            end
            3'b001: begin
               if (boff[0]) begin
                  acc_err = 1'b1;
               end else begin
                  wr_be   = boff[1] ? 4'b1100 : 4'b0011;
                  wr_word = {2{req.wr_data[15:0]}};
               end
            end
            3'b010: begin
               if (boff != 2'b00) acc_err = 1'b1;
               else               wr_be   = 4'b1111;
            end
            default: acc_err = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
               if (boff[0]) acc_err = 1'b1;
               else         ld_data = {{16{ld_half[15]}}, ld_half};
            end
            3'b010: begin
               if (boff != 2'b00) acc_err = 1'b1;
               else               ld_data = rword;
            end
            3'b100: ld_data = {24'd0, ld_byte};
            3'b101: begin
               if (boff[0]) acc_err = 1'b1;
               else         ld_data = {16'd0, ld_half};
            end
            default: acc_err = 1'b1;
         endcase
      end
   end

   // Array has no reset so that stores survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (accept && is_store && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[widx][8*b +: 8] <= wr_word[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         st_store <= '0;
         st_err   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            st_data[i] <= '0;
            st_rob[i]  <= '0;
         end
      end else if (!stall) begin
         st_valid[0] <= accept;
         st_store[0] <= accept & is_store;
         st_err[0]   <= accept & acc_err;
         st_data[0]  <= (accept && !is_store) ? ld_data : 32'd0;
         st_rob[0]   <= accept ? req_robNum : '0;
         for (int i = 1; i < LATENCY; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_store[i] <= st_store[i-1];
            st_err[i]   <= st_err[i-1];
            st_data[i]  <= st_data[i-1];
            st_rob[i]   <= st_rob[i-1];
         end
      end
   end

   assign resp          = '{rd_data: st_data[LATENCY-1], valid: st_valid[LATENCY-1]};
   assign resp_robNum   = st_rob[LATENCY-1];
   assign resp_is_store = st_store[LATENCY-1];
   assign resp_err      = st_err[LATENCY-1];

   a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
      stall |=> ($stable(resp) && $stable(resp_robNum) && $stable(resp_is_store) && $stable(resp_err)));

   a_err_zero_data: assert property (@(posedge clk) disable iff (!rst_n)
      (resp.valid && (resp_err || resp_is_store)) |-> (resp.rd_data == 32'd0));

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int LAT = 2;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  rob;
      logic        st;
      logic        err;
      int          acc;
      bit          chk_lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   memReqStruct  req;
   logic [2:0]   req_funct3;
   logic [3:0]   req_robNum;
   logic         req_ready;
   memRespStruct resp;
   logic [3:0]   resp_robNum;
   logic         resp_is_store;
   logic         resp_err;
   logic         resp_ready;

   exp_t         sb[$];
   exp_t         mon_e;
   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   logic [3:0]   rob_n    = 4'd0;
   bit           lat_on   = 1'b1;

   dmem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_funct3    (req_funct3),
      .req_robNum    (req_robNum),
      .req_ready     (req_ready),
      .resp          (resp),
      .resp_robNum   (resp_robNum),
      .resp_is_store (resp_is_store),
      .resp_err      (resp_err),
      .resp_ready    (resp_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && resp.valid === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("spurious_valid", 32'(resp.valid), 32'd0);
         end else if (resp_ready === 1'b1) begin
            mon_e = sb.pop_front();
            check_eq("rd_data",  resp.rd_data,          mon_e.data);
            check_eq("robNum",   32'(resp_robNum),      32'(mon_e.rob));
            check_eq("is_store", 32'(resp_is_store),    32'(mon_e.st));
            check_eq("err",      32'(resp_err),         32'(mon_e.err));
            if (mon_e.chk_lat) check_eq("latency", 32'(cyc - mon_e.acc + 1), 32'(LAT));
         end else begin
            mon_e = sb[0];
            check_eq("hold_data",  resp.rd_data,     mon_e.data);
            check_eq("hold_rob",   32'(resp_robNum), 32'(mon_e.rob));
            check_eq("stall_rdy",  32'(req_ready),   32'd0);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3, input logic [31:0] exp_data, input bit exp_err);
      exp_t e;
      int   waited;
      req.addr      = addr;
      req.wr_data   = data;
      req.MemRead   = rd;
      req.MemWrite  = wr;
      req_funct3    = f3;
      req_robNum    = rob_n;
      #1;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #2;
         waited++;
      end
      if (req_ready !== 1'b1) begin
         check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
      end else begin
         e.data = exp_data; e.rob = rob_n; e.st = wr; e.err = exp_err;
         e.acc = cyc + 1; e.chk_lat = lat_on;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      req.MemRead  = 1'b0;
      req.MemWrite = 1'b0;
      rob_n++;
   endtask

   task automatic ld(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp_data, input bit exp_err);
      issue(1'b1, 1'b0, addr, 32'd0, f3, exp_data, exp_err);
   endtask

   task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3, input bit exp_err);
      issue(1'b0, 1'b1, addr, data, f3, 32'd0, exp_err);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_valid"},     32'(resp.valid),    32'd0);
      check_eq({pfx, "_rd_data"},   resp.rd_data,       32'd0);
      check_eq({pfx, "_rob"},       32'(resp_robNum),   32'd0);
      check_eq({pfx, "_is_store"},  32'(resp_is_store), 32'd0);
      check_eq({pfx, "_err"},       32'(resp_err),      32'd0);
      check_eq({pfx, "_req_ready"}, 32'(req_ready),     32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      resp_ready   = 1'b1;
      req          = '0;
      req_funct3   = 3'b000;
      req_robNum   = 4'd0;
      #3;
      check_reset_outputs("rst");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("post_rst");

      // SW then LW back-to-back
      st(32'h100, 32'hDEADBEEF, 3'b010, 1'b0);
      ld(32'h100, 3'b010, 32'hDEADBEEF, 1'b0);

      // byte/half accesses on a known word
      st(32'h200, 32'h0000_1234, 3'b010, 1'b0);
      st(32'h203, 32'h0000_0080, 3'b000, 1'b0);
      ld(32'h203, 3'b000, 32'hFFFF_FF80, 1'b0);
      ld(32'h203, 3'b100, 32'h0000_0080, 1'b0);
      ld(32'h202, 3'b101, 32'h0000_8000, 1'b0);
      ld(32'h200, 3'b001, 32'h0000_1234, 1'b0);
      ld(32'h200, 3'b010, 32'h8000_1234, 1'b0);

      // misaligned and illegal funct3
      ld(32'h102, 3'b010, 32'd0, 1'b1);
      st(32'h101, 32'h0000_FFFF, 3'b001, 1'b1);
      ld(32'h100, 3'b010, 32'hDEADBEEF, 1'b0);
      ld(32'h100, 3'b011, 32'd0, 1'b1);
      st(32'h100, 32'h0, 3'b100, 1'b1);
      ld(32'h100, 3'b010, 32'hDEADBEEF, 1'b0);

      // aligned upper halfword store keeps lower lanes
      st(32'h102, 32'h1111_CAFE, 3'b001, 1'b0);
      ld(32'h101, 3'b000, 32'hFFFF_FFBE, 1'b0);
      ld(32'h100, 3'b010, 32'hCAFE_BEEF, 1'b0);

      // address wrap
      st(32'h1000, 32'h1234_5678, 3'b010, 1'b0);
      ld(32'h0, 3'b010, 32'h1234_5678, 1'b0);

      // read+write together behaves as a store
      issue(1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 3'b010, 32'd0, 1'b0);
      ld(32'h300, 3'b010, 32'hA5A5_A5A5, 1'b0);
      drain();

      // backpressure: 3-cycle stall at the first response
      lat_on = 1'b0;
      fork
         begin
            ld(32'h100, 3'b010, 32'hCAFE_BEEF, 1'b0);
            ld(32'h200, 3'b010, 32'h8000_1234, 1'b0);
            ld(32'h0,   3'b010, 32'h1234_5678, 1'b0);
            ld(32'h300, 3'b010, 32'hA5A5_A5A5, 1'b0);
         end
         begin
            for (int k = 0; k < 20; k++) begin
               @(posedge clk); #1;
               if (resp.valid === 1'b1) break;
            end
            check_eq("bp_first_valid", 32'(resp.valid), 32'd1);
            resp_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            resp_ready = 1'b1;
         end
      join
      drain();
      lat_on = 1'b1;

      // reset with two loads in flight
      ld(32'h100, 3'b010, 32'hCAFE_BEEF, 1'b0);
      ld(32'h200, 3'b010, 32'h8000_1234, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("after_mid_rst");

      // array contents survive the reset
      ld(32'h100, 3'b010, 32'hCAFE_BEEF, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
